serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 134 +++++++++++++
 tb/tb_serial_adder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first full-adder chain over WIDTH clock cycles.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds port sub).
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    // Holds the WIDTH-1 sum bits produced so far; the final bit goes straight to sum.
    logic [WIDTH-2:0]   res_sr;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic               s_c;
    logic               cy_c;
    logic               last_c;
    logic               load_c;
    logic [WIDTH-1:0]   res_nxt_c;
    logic [WIDTH-1:0]   b_load_c;
    logic               carry_load_c;

    // Full adder on the current LSBs and the carry flop.
    always_comb begin
        s_c       = a_sr[0] ? ~(b_sr[0] ^ carry) : (b_sr[0] ^ carry);
        cy_c      = a_sr[0] ? (b_sr[0] | carry) : (b_sr[0] & carry);
        res_nxt_c = {s_c, res_sr};
        last_c    = (cnt == CNT_W'(WIDTH - 1));
    end

    // Operand conditioning at load time.
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        b_load_c     = sub ? ~b : b;
        carry_load_c = sub | cin;
`else
        b_load_c     = b;
        carry_load_c = cin;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_c    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_c) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load_c    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            busy <= (state_nxt == RUN);
            done <= (state_nxt == DONE);
            if (load_c) begin
                a_sr   <= a;
                b_sr   <= b_load_c;
                carry  <= carry_load_c;
                cnt    <= '0;
                res_sr <= '0;
            end else if (state == RUN) begin
                a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                carry  <= cy_c;
                cnt    <= cnt + CNT_W'(1);
                res_sr <= res_nxt_c[WIDTH-1:1];
                if (last_c) begin
                    sum  <= res_nxt_c;
                    cout <= cy_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8) with an expected-result queue.
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int checks   = 0;
    int failures = 0;
    logic [WIDTH:0] exp_q[$];

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic c, input logic s);
        logic [WIDTH:0] yy;
        logic [WIDTH:0] cc;
        yy = s ? {1'b0, ~y} : {1'b0, y};
        cc = (s ? 1'b1 : c) ? (WIDTH+1)'(1) : '0;
        return {1'b0, x} + yy + cc;
    endfunction

    // Advance until done, verifying latency and flag exclusivity, then score the result.
    task automatic wait_done(input string tag);
        int n;
        logic [WIDTH:0] e;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
            if (busy && done) check({tag, "_excl"}, 32'(busy & done), 32'(0));
        end
        check({tag, "_latency"}, 32'(n), 32'(WIDTH));
        check({tag, "_busy_at_done"}, 32'(busy), 32'(0));
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'(0), 32'(1));
        end else begin
            e = exp_q.pop_front();
            check({tag, "_sum"}, 32'(sum), 32'(e[WIDTH-1:0]));
            check({tag, "_cout"}, 32'(cout), 32'(e[WIDTH]));
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tc, input logic ts, input string tag);
        a     = ta;
        b     = tb;
        cin   = tc;
        sub   = ts;
        start = 1'b1;
        exp_q.push_back(model(ta, tb, tc, ts));
        tick();
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'(1));
        wait_done(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_sum", 32'(sum), 32'(0));
        check("rst_cout", 32'(cout), 32'(0));
        #22 rst_n = 1'b1;
        tick();

        run_op(8'h5A, 8'h33, 1'b0, 1'b0, "op5a33");
        tick();
        check("done_pulse", 32'(done), 32'(0));
        check("idle_busy", 32'(busy), 32'(0));
        check("sum_hold", 32'(sum), 32'(8'h8D));

        run_op(8'hFF, 8'h01, 1'b0, 1'b0, "opff01");
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, "opffff");
        tick();

        // Start held through RUN with new operands; restart from DONE without a gap.
        a     = 8'h22;
        b     = 8'h11;
        cin   = 1'b0;
        start = 1'b1;
        exp_q.push_back(model(8'h22, 8'h11, 1'b0, 1'b0));
        tick();
        a = 8'h01;
        b = 8'h01;
        exp_q.push_back(model(8'h01, 8'h01, 1'b0, 1'b0));
        wait_done("b2b_first");
        tick();
        start = 1'b0;
        check("b2b_restart_busy", 32'(busy), 32'(1));
        check("b2b_restart_done", 32'(done), 32'(0));
        check("b2b_sum_hold", 32'(sum), 32'(8'h33));
        wait_done("b2b_second");
        tick();

        // Reset in the middle of an operation.
        a     = 8'h77;
        b     = 8'h77;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        check("midrst_sum", 32'(sum), 32'(0));
        check("midrst_cout", 32'(cout), 32'(0));
        #1 rst_n = 1'b1;
        run_op(8'h10, 8'h20, 1'b0, 1'b0, "op_after_rst");

        for (int i = 0; i < 4; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0, "rand");
        end

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, "sub10_01");
        run_op(8'h00, 8'h01, 1'b1, 1'b1, "sub00_01");
`endif

        check("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
